// File: rtl/command_serializer_pkg.sv
// Shared command codes, frame-format flag positions and serializer state encoding
// for the host-side control byte-stream transmitter.
package command_serializer_pkg;

  localparam int BLOCK_INSTR_WIDTH    = 32;
  localparam int BLOCK_REG_ADDR_WIDTH = 4;

  localparam logic [7:0] COMMAND_WRITE_BLOCK_INSTR  = 8'h01;
  localparam logic [7:0] COMMAND_WRITE_BLOCK_REG    = 8'h02;
  localparam logic [7:0] COMMAND_UPDATE_BLOCK_REG   = 8'h03;
  localparam logic [7:0] COMMAND_ALLOC_SRAM_DELAY   = 8'h04;
  localparam logic [7:0] COMMAND_SET_INPUT_GAIN     = 8'h05;
  localparam logic [7:0] COMMAND_SET_OUTPUT_GAIN    = 8'h06;
  localparam logic [7:0] COMMAND_COMMIT_REG_UPDATES = 8'h07;
  localparam logic [7:0] COMMAND_SWAP_PIPELINES     = 8'h08;
  localparam logic [7:0] COMMAND_RESET_PIPELINE     = 8'h09;

  // Flag bit order matches the order fields appear on the wire.
  localparam int HAS_BLOCK = 0;
  localparam int HAS_REG   = 1;
  localparam int HAS_DATA  = 2;
  localparam int HAS_INSTR = 3;
  localparam int HAS_DELAY = 4;
  localparam int UNKNOWN   = 5;

  typedef logic [5:0] fmt_flags_t;

  typedef enum logic [2:0] {
    SERIALIZER_STATE_IDLE      = 3'd0,
    SERIALIZER_STATE_WAIT_PEER = 3'd1,
    SERIALIZER_STATE_CMD       = 3'd2,
    SERIALIZER_STATE_BLOCK     = 3'd3,
    SERIALIZER_STATE_REG       = 3'd4,
    SERIALIZER_STATE_DATA      = 3'd5,
    SERIALIZER_STATE_INSTR     = 3'd6,
    SERIALIZER_STATE_DELAY     = 3'd7
  } ser_state_e;

  function automatic ser_state_e next_field(input ser_state_e cur, input fmt_flags_t flags);
    logic [4:0] rest;
    case (cur)
      SERIALIZER_STATE_CMD:   rest = flags[4:0];
      SERIALIZER_STATE_BLOCK: rest = flags[4:0] & 5'b11110;
      SERIALIZER_STATE_REG:   rest = flags[4:0] & 5'b11100;
      SERIALIZER_STATE_DATA:  rest = flags[4:0] & 5'b11000;
      SERIALIZER_STATE_INSTR: rest = flags[4:0] & 5'b10000;
      default:                rest = 5'b00000;
    endcase
    if (rest[HAS_BLOCK])      next_field = SERIALIZER_STATE_BLOCK;
    else if (rest[HAS_REG])   next_field = SERIALIZER_STATE_REG;
    else if (rest[HAS_DATA])  next_field = SERIALIZER_STATE_DATA;
    else if (rest[HAS_INSTR]) next_field = SERIALIZER_STATE_INSTR;
    else if (rest[HAS_DELAY]) next_field = SERIALIZER_STATE_DELAY;
    else                      next_field = SERIALIZER_STATE_IDLE;
  endfunction

endpackage

// File: rtl/command_serializer_format_decode.sv
// Maps a command byte to the set of fields its frame carries.
module command_format_decode
  import command_serializer_pkg::*;
(
  input  logic [7:0] cmd_i,
  output fmt_flags_t flags_o
);

  always_comb begin
    flags_o = 6'b000000;
    case (cmd_i)
      COMMAND_WRITE_BLOCK_INSTR: begin
        flags_o[HAS_BLOCK] = 1'b1;
        flags_o[HAS_INSTR] = 1'b1;
      end
      COMMAND_WRITE_BLOCK_REG, COMMAND_UPDATE_BLOCK_REG: begin
        flags_o[HAS_BLOCK] = 1'b1;
        flags_o[HAS_REG]   = 1'b1;
        flags_o[HAS_DATA]  = 1'b1;
      end
      COMMAND_ALLOC_SRAM_DELAY: begin
        flags_o[HAS_DATA]  = 1'b1;
        flags_o[HAS_DELAY] = 1'b1;
      end
      COMMAND_SET_INPUT_GAIN, COMMAND_SET_OUTPUT_GAIN: flags_o[HAS_DATA] = 1'b1;
      COMMAND_COMMIT_REG_UPDATES, COMMAND_SWAP_PIPELINES,
      COMMAND_RESET_PIPELINE:    flags_o = 6'b000000;
      default:                   flags_o[UNKNOWN] = 1'b1;
    endcase
  end

endmodule

// File: rtl/command_serializer.sv
// Accepts one command request and emits its frame byte by byte, advancing on the
// receiver's next pulse; a stalled byte aborts the frame after timeout_cycles.
module command_serializer
  import command_serializer_pkg::*;
#(
  parameter int n_blocks       = 32,
  parameter int data_width     = 16,
  parameter int instr_width    = BLOCK_INSTR_WIDTH,
  parameter int timeout_cycles = 65535
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [7:0]                      req_cmd,
  input  logic [$clog2(n_blocks)-1:0]     req_block,
  input  logic [BLOCK_REG_ADDR_WIDTH-1:0] req_reg,
  input  logic [data_width-1:0]           req_data,
  input  logic [instr_width-1:0]          req_instr,
  input  logic [31:0]                     req_delay,
  input  logic                            peer_idle,
  output logic [7:0]                      out_byte,
  output logic                            out_ready,
  input  logic                            next,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            req_unknown,
  output logic                            timeout
);

  localparam int BW = $clog2(n_blocks);
  localparam int TW = (timeout_cycles > 1) ? $clog2(timeout_cycles + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(timeout_cycles - 1);
  localparam logic [7:0]    DATA_LAST  = 8'(data_width / 8 - 1);
  localparam logic [7:0]    INSTR_LAST = 8'(instr_width / 8 - 1);
  localparam logic [7:0]    DELAY_LAST = 8'd3;

  ser_state_e                      state_q, state_d, nf_s, load_state_s;
  fmt_flags_t                      flags_q, flags_d, dec_flags_s;
  logic [7:0]                      cmd_q, cmd_d, out_byte_q, out_byte_d;
  logic [BW-1:0]                   block_q, block_d;
  logic [BLOCK_REG_ADDR_WIDTH-1:0] reg_q, reg_d;
  logic [data_width-1:0]           data_q, data_d;
  logic [instr_width-1:0]          instr_q, instr_d;
  logic [31:0]                     delay_q, delay_d;
  logic [7:0]                      byte_ctr_q, byte_ctr_d, field_last_s;
  logic [TW-1:0]                   tmo_ctr_q, tmo_ctr_d;
  logic                            out_ready_q, out_ready_d, frame_done_q, frame_done_d;
  logic                            req_unknown_q, req_unknown_d, timeout_q, timeout_d;
  logic                            load_en_s;

  command_format_decode u_decode (
    .cmd_i   (req_cmd),
    .flags_o (dec_flags_s)
  );

  always_comb begin
    case (state_q)
      SERIALIZER_STATE_DATA:  field_last_s = DATA_LAST;
      SERIALIZER_STATE_INSTR: field_last_s = INSTR_LAST;
      SERIALIZER_STATE_DELAY: field_last_s = DELAY_LAST;
      default:                field_last_s = 8'd0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    flags_d       = flags_q;
    cmd_d         = cmd_q;
    block_d       = block_q;
    reg_d         = reg_q;
    data_d        = data_q;
    instr_d       = instr_q;
    delay_d       = delay_q;
    byte_ctr_d    = byte_ctr_q;
    tmo_ctr_d     = tmo_ctr_q;
    out_byte_d    = out_byte_q;
    out_ready_d   = out_ready_q;
    frame_done_d  = 1'b0;
    req_unknown_d = 1'b0;
    timeout_d     = 1'b0;
    load_en_s     = 1'b0;
    load_state_s  = SERIALIZER_STATE_CMD;
    nf_s          = next_field(state_q, flags_q);

    case (state_q)
      SERIALIZER_STATE_IDLE: begin
        if (req_valid) begin
          cmd_d         = req_cmd;
          block_d       = req_block;
          reg_d         = req_reg;
          data_d        = req_data;
          instr_d       = req_instr;
          delay_d       = req_delay;
          flags_d       = dec_flags_s;
          req_unknown_d = dec_flags_s[UNKNOWN];
          state_d       = SERIALIZER_STATE_WAIT_PEER;
        end
      end
      SERIALIZER_STATE_WAIT_PEER: begin
        if (peer_idle) begin
          state_d     = SERIALIZER_STATE_CMD;
          out_ready_d = 1'b1;
          byte_ctr_d  = 8'd0;
          load_en_s   = 1'b1;
        end
      end
      default: begin
        // next takes priority over an expiring byte timer.
        if (out_ready_q && next) begin
          if (byte_ctr_q != field_last_s) begin
            byte_ctr_d   = byte_ctr_q + 8'd1;
            load_en_s    = 1'b1;
            load_state_s = state_q;
          end else if (nf_s == SERIALIZER_STATE_IDLE) begin
            state_d      = SERIALIZER_STATE_IDLE;
            out_ready_d  = 1'b0;
            frame_done_d = 1'b1;
            byte_ctr_d   = 8'd0;
          end else begin
            state_d      = nf_s;
            byte_ctr_d   = 8'd0;
            load_en_s    = 1'b1;
            load_state_s = nf_s;
          end
        end else if (timeout_cycles != 0 && out_ready_q && tmo_ctr_q == TMO_LAST) begin
          state_d     = SERIALIZER_STATE_IDLE;
          out_ready_d = 1'b0;
          timeout_d   = 1'b1;
          byte_ctr_d  = 8'd0;
        end else if (out_ready_q) begin
          tmo_ctr_d = tmo_ctr_q + 1'b1;
        end
      end
    endcase

    // Multi-byte fields shift left so the top byte is always the next one out.
    if (load_en_s) begin
      tmo_ctr_d = '0;
      case (load_state_s)
        SERIALIZER_STATE_BLOCK: out_byte_d = 8'(block_q);
        SERIALIZER_STATE_REG:   out_byte_d = 8'(reg_q);
        SERIALIZER_STATE_DATA: begin
          out_byte_d = data_q[data_width-1 -: 8];
          data_d     = data_q << 4'd8;
        end
        SERIALIZER_STATE_INSTR: begin
          out_byte_d = instr_q[instr_width-1 -: 8];
          instr_d    = instr_q << 4'd8;
        end
        SERIALIZER_STATE_DELAY: begin
          out_byte_d = delay_q[31:24];
          delay_d    = delay_q << 4'd8;
        end
        default: out_byte_d = cmd_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= SERIALIZER_STATE_IDLE;
      flags_q       <= 6'b000000;
      cmd_q         <= 8'h00;
      block_q       <= '0;
      reg_q         <= '0;
      data_q        <= '0;
      instr_q       <= '0;
      delay_q       <= 32'h0000_0000;
      byte_ctr_q    <= 8'd0;
      tmo_ctr_q     <= '0;
      out_byte_q    <= 8'h00;
      out_ready_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      req_unknown_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      flags_q       <= flags_d;
      cmd_q         <= cmd_d;
      block_q       <= block_d;
      reg_q         <= reg_d;
      data_q        <= data_d;
      instr_q       <= instr_d;
      delay_q       <= delay_d;
      byte_ctr_q    <= byte_ctr_d;
      tmo_ctr_q     <= tmo_ctr_d;
      out_byte_q    <= out_byte_d;
      out_ready_q   <= out_ready_d;
      frame_done_q  <= frame_done_d;
      req_unknown_q <= req_unknown_d;
      timeout_q     <= timeout_d;
    end
  end

  assign req_ready   = (state_q == SERIALIZER_STATE_IDLE);
  assign busy        = (state_q != SERIALIZER_STATE_IDLE);
  assign out_byte    = out_byte_q;
  assign out_ready   = out_ready_q;
  assign frame_done  = frame_done_q;
  assign req_unknown = req_unknown_q;
  assign timeout     = timeout_q;

endmodule
